bg_ram_arbiter: RTL
===================

// Module: bg_ram_arbiter
// PURPOSE
//  Shares the single-port background tile RAM (2x 2Kx8, lo/hi bytes) between the video tile fetch and
//  Z80 CPU accesses. Video fetch has absolute priority; CPU accesses are stretched via active-low BG_WAIT.
//  Sits between the Z80 bus decode (BACKGRAM_1/2) and the background layer's tile-code pipeline.
// PARAMETERS
//  ADDR_W    11  tile RAM address width (64x32 tile map)
//  MIN_WAIT  2   minimum master_clk cycles BG_WAIT is held low per CPU access (>=1)
// PORTS
//  master_clk    in   1       system clock; all logic rising-edge
//  RESET_N       in   1       asynchronous active-low reset
//  VID_REQ       in   1       1-cycle pulse: tile fetch wants VID_ADDR read; spacing >=4 cycles
//  VID_ADDR      in   ADDR_W  tile map address {V[7:3],H[8:3]}, sampled with VID_REQ
//  VID_DATA      out  16      tile word {hi,lo} read for video
//  VID_VALID     out  1       1-cycle pulse, VID_DATA updated this cycle
//  VID_MISS      out  1       sticky: VID_REQ arrived while a video request was already pending
//  BACKGRAM_1    in   1       active-low CPU select, lo byte RAM
//  BACKGRAM_2    in   1       active-low CPU select, hi byte RAM
//  Z80_WR        in   1       active-low write strobe
//  CPU_ADDR      in   ADDR_W  CPU address
//  CPU_DIN       in   8       CPU write data
//  CPU_DOUT      out  8       read data for selected byte, held until next CPU access
//  BG_WAIT       out  1       active-low Z80 wait request
//  RAM_ADDR      out  ADDR_W  shared RAM address
//  RAM_WE_LO     out  1       active-high write enable, lo RAM
//  RAM_WE_HI     out  1       active-high write enable, hi RAM
//  RAM_DIN       out  8       RAM write data
//  RAM_Q         in   16      RAM read data {hi,lo}, registered, 1-cycle latency
// BEHAVIOUR
//  Reset: state=IDLE; BG_WAIT=1; RAM_WE_*=0; VID_VALID=0; VID_MISS=0; VID_DATA=0; CPU_DOUT=0;
//   RAM_ADDR=0; pending flags cleared. Reset mid-access aborts it; no write issued after RESET_N falls.
//  CPU start: falling edge of CS=BACKGRAM_1&BACKGRAM_2 (registered compare) sets cpu_pend and drives
//   BG_WAIT=0 that same cycle (combinational on CS low & !cpu_done); one access per CS assertion.
//  VID_REQ sets vid_pend and latches VID_ADDR; if vid_pend already set -> VID_MISS=1, new addr dropped.
//  FSM (one transition per cycle):
//   IDLE     : vid_pend -> VID_RD; else cpu_pend -> CPU_RD; else stay.
//   VID_RD   : RAM_ADDR=vid_addr; clear vid_pend -> VID_CAP.
//   VID_CAP  : VID_DATA<=RAM_Q, VID_VALID=1 -> IDLE.
//   CPU_RD   : RAM_ADDR=CPU_ADDR; if !Z80_WR: RAM_DIN=CPU_DIN, RAM_WE_LO=!BACKGRAM_1,
//              RAM_WE_HI=!BACKGRAM_2 for exactly this cycle -> CPU_CAP.
//   CPU_CAP  : CPU_DOUT<=BACKGRAM_1 ? RAM_Q[15:8] : RAM_Q[7:0]; clear cpu_pend; set cpu_done -> IDLE.
//  Video latency: VID_REQ in IDLE -> VID_VALID 2 cycles later; worst case (CPU_RD in flight) 4 cycles.
//  Simultaneous VID_REQ and CPU CS fall in IDLE: video served first, CPU follows immediately.
//  VID_REQ during CPU_RD/CPU_CAP: served in the IDLE cycle following CPU_CAP.
//  BG_WAIT release: 1 once cpu_done and >=MIN_WAIT cycles elapsed since CS fall (saturating counter).
//  cpu_done held until CS rises; CS rising before done: access still completes, no extra write.
//  CS low with no falling edge seen (held through reset): no access until CS rises and falls again.
//  Both selects low: write both bytes; read returns lo byte.
// TESTING
//  1 Reset: RESET_N=0 with CS low -> BG_WAIT=1, RAM_WE_*=0, VID_VALID=0 throughout.
//  2 VID_REQ addr 0x123, RAM_Q=0xA55A -> RAM_ADDR=0x123 next cycle, VID_VALID+VID_DATA=0xA55A at +2.
//  3 CPU write BACKGRAM_2=0, addr 0x7FF, data 0x3C -> one RAM_WE_HI pulse, RAM_WE_LO=0, BG_WAIT low
//    >=MIN_WAIT cycles, then high while CS remains low; no second write.
//  4 VID_REQ and CS fall same cycle -> VID_RD then CPU_RD; BG_WAIT low until CPU_CAP done.
//  5 Two VID_REQs 1 cycle apart -> VID_MISS=1 sticky, single VID_VALID with first address's data.
//  6 CPU read lo addr 0x040, RAM_Q=0x12EF -> CPU_DOUT=0xEF; RESET_N pulse mid CPU_RD -> no write.

Source files
------------

// File: rtl/bg_ram_arbiter.sv
// Background tile RAM arbiter: video tile fetch and Z80 share one RAM port.
// Video always wins arbitration; the CPU is held off with active-low BG_WAIT.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | port free; pick video if pending or requesting, else CPU
// S_VID_RD  | present latched video address to the RAM
// S_VID_CAP | RAM_Q holds video word; pulse VID_VALID
// S_CPU_RD  | present CPU address; write strobes for selected bytes
// S_CPU_CAP | RAM_Q holds CPU word; capture selected byte into CPU_DOUT
module bg_ram_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MIN_WAIT = 2
) (
  input  logic              master_clk,
  input  logic              RESET_N,
  input  logic              VID_REQ,
  input  logic [ADDR_W-1:0] VID_ADDR,
  output logic [15:0]       VID_DATA,
  output logic              VID_VALID,
  output logic              VID_MISS,
  input  logic              BACKGRAM_1,
  input  logic              BACKGRAM_2,
  input  logic              Z80_WR,
  input  logic [ADDR_W-1:0] CPU_ADDR,
  input  logic [7:0]        CPU_DIN,
  output logic [7:0]        CPU_DOUT,
  output logic              BG_WAIT,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic              RAM_WE_LO,
  output logic              RAM_WE_HI,
  output logic [7:0]        RAM_DIN,
  input  logic [15:0]       RAM_Q
);

  localparam int CNT_W = $clog2(MIN_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VID_RD,
    S_VID_CAP,
    S_CPU_RD,
    S_CPU_CAP
  } state_t;

  state_t             state_q, state_d;
  logic               cs_high_q;
  logic               cpu_pend, cpu_done;
  logic               vid_pend;
  logic [ADDR_W-1:0]  vid_addr;
  logic [15:0]        vid_data_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               cs_low, cs_fall, cnt_ok;

  // cs_high_q resets low so a select held through reset is not seen as a new access
  assign cs_low  = ~(BACKGRAM_1 & BACKGRAM_2);
  assign cs_fall = cs_high_q & cs_low;
  assign cnt_ok  = (wait_cnt >= CNT_W'(MIN_WAIT));

  assign BG_WAIT  = ~(cs_low & (cs_fall | cpu_pend | (cpu_done & ~cnt_ok)));
  assign VID_DATA = (state_q == S_VID_CAP) ? RAM_Q : vid_data_q;

  // arbitration state register
  always_ff @(posedge master_clk or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // CPU access tracking: edge detect, pending/done flags, minimum-wait counter
  always_ff @(posedge master_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      cs_high_q <= 1'b0;
      cpu_pend  <= 1'b0;
      cpu_done  <= 1'b0;
      wait_cnt  <= '0;
      CPU_DOUT  <= 8'h00;
    end else begin
      cs_high_q <= ~cs_low;
      if (cs_fall)                     cpu_pend <= 1'b1;
      else if (state_q == S_CPU_CAP)   cpu_pend <= 1'b0;
      if (!cs_low)                     cpu_done <= 1'b0;
      else if (state_q == S_CPU_CAP)   cpu_done <= 1'b1;
      if (cs_fall)                     wait_cnt <= CNT_W'(1);
      else if (cs_low && !cnt_ok)      wait_cnt <= wait_cnt + CNT_W'(1);
      if (state_q == S_CPU_CAP)
        CPU_DOUT <= BACKGRAM_1 ? RAM_Q[15:8] : RAM_Q[7:0];
    end
  end

  // video request latch; a request arriving while one is still pending is dropped
  always_ff @(posedge master_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      vid_pend   <= 1'b0;
      vid_addr   <= '0;
      VID_MISS   <= 1'b0;
      vid_data_q <= 16'h0000;
    end else begin
      if (VID_REQ && !vid_pend) begin
        vid_pend <= 1'b1;
        vid_addr <= VID_ADDR;
      end else if (state_q == S_VID_RD) begin
        vid_pend <= 1'b0;
      end
      if (VID_REQ && vid_pend) VID_MISS <= 1'b1;
      if (state_q == S_VID_CAP) vid_data_q <= RAM_Q;
    end
  end

  // next state and RAM port drive
  always_comb begin
    state_d   = state_q;
    RAM_ADDR  = '0;
    RAM_WE_LO = 1'b0;
    RAM_WE_HI = 1'b0;
    RAM_DIN   = 8'h00;
    VID_VALID = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vid_pend || VID_REQ) state_d = S_VID_RD;
        else if (cpu_pend)       state_d = S_CPU_RD;
      end
      S_VID_RD: begin
        RAM_ADDR = vid_addr;
        state_d  = S_VID_CAP;
      end
      S_VID_CAP: begin
        VID_VALID = 1'b1;
        state_d   = S_IDLE;
      end
      S_CPU_RD: begin
        RAM_ADDR = CPU_ADDR;
        if (!Z80_WR) begin
          RAM_DIN   = CPU_DIN;
          RAM_WE_LO = ~BACKGRAM_1;
          RAM_WE_HI = ~BACKGRAM_2;
        end
        state_d = S_CPU_CAP;
      end
      S_CPU_CAP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
